// File: rtl/load_data_align.sv
// Load-side byte-lane extractor: accepts a load in MEM, samples the SRAM word one cycle later and
// registers the aligned, sign/zero-extended result for WB. Optional LD_MISALIGN_TRAP_EN adds ld_misalign.
module load_data_align #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req,
  input  logic [2:0]        ld_func3,
  input  logic [1:0]        ld_byte_addr,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic [XLEN-1:0]   mem_do,
  input  logic              stall,
  output logic              ld_busy,
  output logic              ld_valid,
  output logic [XLEN-1:0]   ld_data,
  output logic [REG_AW-1:0] ld_rd_out
`ifdef LD_MISALIGN_TRAP_EN
  ,
  output logic              ld_misalign
`endif
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;

  state_t              state_reg;
  logic [2:0]          func3_reg;
  logic [1:0]          addr_reg;
  logic [REG_AW-1:0]   rd_reg;
  logic                accept;
  logic [7:0]          lanes [XLEN/8];
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [XLEN-1:0]     data_next;

  assign ld_busy  = (state_reg == WAIT) | ((state_reg == OUT) & stall);
  assign accept   = ld_req & ~ld_busy;
  assign ld_valid = (state_reg == OUT);

  for (genvar gi = 0; gi < XLEN/8; gi++) begin : g_lane
    assign lanes[gi] = mem_do[8*gi +: 8];
  end

  assign byte_sel = lanes[addr_reg];
  assign half_sel = addr_reg[1] ? mem_do[31:16] : mem_do[15:0];

  // func3[2] marks the unsigned variants; misaligned and unsupported encodings fall through to zero.
  always_comb begin
    data_next = '0;
    case (func3_reg)
      F3_LB, F3_LBU: data_next = {{(XLEN-8){byte_sel[7] & ~func3_reg[2]}}, byte_sel};
      F3_LH, F3_LHU: begin
        if (!addr_reg[0]) data_next = {{(XLEN-16){half_sel[15] & ~func3_reg[2]}}, half_sel};
      end
      F3_LW: begin
        if (addr_reg == 2'b00) data_next = mem_do;
      end
      default: data_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      func3_reg <= '0;
      addr_reg  <= '0;
      rd_reg    <= '0;
      ld_data   <= '0;
      ld_rd_out <= '0;
    end else begin
      if (accept) begin
        func3_reg <= ld_func3;
        addr_reg  <= ld_byte_addr;
        rd_reg    <= ld_rd;
      end
      case (state_reg)
        IDLE: if (accept) state_reg <= WAIT;
        WAIT: begin
          // SRAM word is only valid in this cycle, so it is captured unconditionally.
          state_reg <= OUT;
          ld_data   <= data_next;
          ld_rd_out <= rd_reg;
        end
        OUT: if (!stall) state_reg <= accept ? WAIT : IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef LD_MISALIGN_TRAP_EN
  logic misalign_next;
  logic misalign_reg;

  assign misalign_next = (((func3_reg == F3_LH) | (func3_reg == F3_LHU)) & addr_reg[0])
                       | ((func3_reg == F3_LW) & (addr_reg != 2'b00));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_reg <= 1'b0;
    end else if (state_reg == WAIT) begin
      misalign_reg <= misalign_next;
    end else if ((state_reg == OUT) && !stall) begin
      misalign_reg <= 1'b0;
    end
  end

  assign ld_misalign = misalign_reg;
`else
  // Without the trap port a misaligned load is visible only as a zero result.
`endif

endmodule

// File: tb/tb_load_data_align.sv
// Randomized + directed bench for load_data_align against a transaction-queue reference model.
module tb_load_data_align;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_req = 1'b0;
  logic [2:0]  ld_func3 = '0;
  logic [1:0]  ld_byte_addr = '0;
  logic [4:0]  ld_rd = '0;
  logic [31:0] mem_do = '0;
  logic        stall = 1'b0;
  logic        ld_busy;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic [4:0]  ld_rd_out;
`ifdef LD_MISALIGN_TRAP_EN
  logic        ld_misalign;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic last_acc = 1'b0;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  a;
    logic [4:0]  rd;
    int          ready;
    logic [31:0] data;
    logic        mis;
  } ld_t;

  ld_t q[$];

  load_data_align #(.XLEN(32), .REG_AW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .ld_req       (ld_req),
    .ld_func3     (ld_func3),
    .ld_byte_addr (ld_byte_addr),
    .ld_rd        (ld_rd),
    .mem_do       (mem_do),
    .stall        (stall),
    .ld_busy      (ld_busy),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_rd_out    (ld_rd_out)
`ifdef LD_MISALIGN_TRAP_EN
    ,
    .ld_misalign  (ld_misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference extraction from the load rules, using shifts and integer arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] md, output logic mis);
    logic [31:0] sh;
    int b, h;
    sh  = md >> (8 * a);
    mis = 1'b0;
    case (f3)
      LB: begin
        b = int'(sh & 32'hFF);
        if (b >= 128) b -= 256;
        return 32'(b);
      end
      LBU: return sh & 32'hFF;
      LH, LHU: begin
        if (a % 2 == 1) begin
          mis = 1'b1;
          return 32'd0;
        end
        h = int'(sh & 32'hFFFF);
        if (f3 == LH && h >= 32768) h -= 65536;
        return 32'(h);
      end
      LW: begin
        if (a != 0) begin
          mis = 1'b1;
          return 32'd0;
        end
        return md;
      end
      default: return 32'd0;
    endcase
  endfunction

  task automatic do_cycle(input logic req, input logic [2:0] f3, input logic [1:0] a,
                          input logic [4:0] rd, input logic [31:0] md, input logic st);
    logic vexp, bexp, acc;
    ld_t  e;
    @(posedge clk);
    #1;
    cyc++;
    vexp = (q.size() > 0) && (cyc >= q[0].ready);
    check("ld_valid", 32'(ld_valid), 32'(vexp));
    if (vexp) begin
      check("ld_data", ld_data, q[0].data);
      check("ld_rd_out", 32'(ld_rd_out), 32'(q[0].rd));
`ifdef LD_MISALIGN_TRAP_EN
      check("ld_misalign", 32'(ld_misalign), 32'(q[0].mis));
`endif
    end
    ld_req       = req;
    ld_func3     = f3;
    ld_byte_addr = a;
    ld_rd        = rd;
    mem_do       = md;
    stall        = st;
    #1;
    bexp = ((q.size() > 0) && (cyc < q[0].ready)) || (vexp && st);
    check("ld_busy", 32'(ld_busy), 32'(bexp));
    if ((q.size() > 0) && (q[q.size()-1].ready == cyc + 1)) begin
      e = q[q.size()-1];
      e.data = ref_load(e.f3, e.a, md, e.mis);
      q[q.size()-1] = e;
    end
    if (vexp && !st) begin
      $display("load done: f3=%0d a=%0d rd=%0d data=%h", q[0].f3, q[0].a, q[0].rd, q[0].data);
      void'(q.pop_front());
    end
    acc = req && !bexp;
    if (acc) begin
      e.f3 = f3; e.a = a; e.rd = rd; e.ready = cyc + 2; e.data = '0; e.mis = 1'b0;
      q.push_back(e);
    end
    last_acc = acc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, LB, 2'd0, 5'd0, $urandom, 1'b0);
  endtask

  initial begin
    logic        r_req;
    logic [2:0]  r_f3;
    logic [1:0]  r_a;
    logic [4:0]  r_rd;
    logic        refused;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(ld_valid), 32'd0);
    check("rst_busy", 32'(ld_busy), 32'd0);
    check("rst_data", ld_data, 32'd0);
    check("rst_rd", 32'(ld_rd_out), 32'd0);
    @(negedge clk) rst = 1'b1;

    // LB sign extension from lane 3
    do_cycle(1'b1, LB, 2'd3, 5'd5, 32'h0, 1'b0);
    do_cycle(1'b0, LB, 2'd0, 5'd0, 32'h80FF_1234, 1'b0);
    do_cycle(1'b0, LB, 2'd0, 5'd0, 32'h0, 1'b0);
    check("lb_a3", ld_data, 32'hFFFF_FF80);
    idle(2);

    // LBU then LHU, second issued on the consume cycle
    do_cycle(1'b1, LBU, 2'd1, 5'd2, 32'h0, 1'b0);
    do_cycle(1'b0, LB, 2'd0, 5'd0, 32'hA5B6_C7D8, 1'b0);
    do_cycle(1'b1, LHU, 2'd2, 5'd3, 32'h0, 1'b0);
    check("lbu_a1", ld_data, 32'h0000_00C7);
    do_cycle(1'b0, LB, 2'd0, 5'd0, 32'hA5B6_C7D8, 1'b0);
    do_cycle(1'b0, LB, 2'd0, 5'd0, 32'h0, 1'b0);
    check("lhu_a2", ld_data, 32'h0000_A5B6);
    idle(2);

    // LH held under a 3-cycle stall, next request held and accepted on release
    do_cycle(1'b1, LH, 2'd0, 5'd4, 32'h0, 1'b0);
    do_cycle(1'b0, LB, 2'd0, 5'd0, 32'h1234_8001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b1, LW, 2'd0, 5'd6, $urandom, 1'b1);
      check("lh_stall_data", ld_data, 32'hFFFF_8001);
    end
    do_cycle(1'b1, LW, 2'd0, 5'd6, $urandom, 1'b0);
    check("lh_release_data", ld_data, 32'hFFFF_8001);
    check("release_accept", 32'(last_acc), 32'd1);
    idle(3);

    // Back-to-back LW: second refused in WAIT, accepted in OUT
    do_cycle(1'b1, LW, 2'd0, 5'd7, 32'h0, 1'b0);
    do_cycle(1'b1, LW, 2'd0, 5'd9, 32'hDEAD_BEEF, 1'b0);
    check("lw_refused_wait", 32'(last_acc), 32'd0);
    do_cycle(1'b1, LW, 2'd0, 5'd9, 32'h0, 1'b0);
    check("lw_rd7", 32'(ld_rd_out), 32'd7);
    check("lw_data7", ld_data, 32'hDEAD_BEEF);
    do_cycle(1'b0, LB, 2'd0, 5'd0, 32'hDEAD_BEEF, 1'b0);
    do_cycle(1'b0, LB, 2'd0, 5'd0, 32'h0, 1'b0);
    check("lw_rd9", 32'(ld_rd_out), 32'd9);
    idle(2);

    // Misaligned LH / LW return zero
    do_cycle(1'b1, LH, 2'd1, 5'd10, 32'h0, 1'b0);
    do_cycle(1'b0, LB, 2'd0, 5'd0, 32'hFFFF_FFFF, 1'b0);
    do_cycle(1'b1, LW, 2'd2, 5'd11, 32'h0, 1'b0);
    check("lh_misaligned", ld_data, 32'd0);
    do_cycle(1'b0, LB, 2'd0, 5'd0, 32'hFFFF_FFFF, 1'b0);
    do_cycle(1'b0, LB, 2'd0, 5'd0, 32'h0, 1'b0);
    check("lw_misaligned", ld_data, 32'd0);
    idle(2);

    // Reset while a load sits in WAIT
    do_cycle(1'b1, LW, 2'd0, 5'd12, 32'h0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    ld_req = 1'b0;
    #1;
    q.delete();
    check("midrst_valid", 32'(ld_valid), 32'd0);
    check("midrst_busy", 32'(ld_busy), 32'd0);
    check("midrst_data", ld_data, 32'd0);
    @(negedge clk) rst = 1'b1;
    idle(3);

    // Random traffic; a refused request is held unchanged by the issuer
    refused = 1'b0;
    r_req = 1'b0; r_f3 = '0; r_a = '0; r_rd = '0;
    for (int i = 0; i < 600; i++) begin
      if (!refused) begin
        r_req = ($urandom_range(0, 99) < 60);
        r_f3  = 3'($urandom_range(0, 7));
        r_a   = 2'($urandom_range(0, 3));
        r_rd  = 5'($urandom_range(0, 31));
      end
      do_cycle(r_req, r_f3, r_a, r_rd, $urandom, ($urandom_range(0, 99) < 35));
      refused = r_req && !last_acc;
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
